// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store data-memory adapter and its load
// aligner: access-size encodings, the adapter state type and a helper that
// turns per-byte enables into a per-bit write mask.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Access size encodings (byte count = 1 << size)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Each set byte enable becomes an 8'hFF lane in the 64-bit bit mask.
    function automatic logic [63:0] byte_mask_expand(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load aligner. Treats {i_hi, i_lo} as a 16-byte window,
// extracts the (1 << i_size)-byte field starting at byte i_off and returns it
// right-aligned, sign- or zero-extended to 64 bits.
//
// Ports:
//   i_hi     in  64  upper dword of the window (0 when the access fits in i_lo)
//   i_lo     in  64  lower dword of the window
//   i_off    in   3  starting byte within i_lo
//   i_size   in   2  access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   i_signed in   1  sign-extend the result (ignored for SZ_D)
//   o_data   out 64  extended result
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_hi,
    input  logic [63:0] i_lo,
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [63:0] o_data
);

    logic [6:0]  w_sh_lo;
    logic [6:0]  w_sh_hi;
    logic [63:0] w_raw;

    // Funnel shift of the 128-bit window; a left shift of 64 (off = 0)
    // yields zero, so i_hi contributes nothing when the offset is zero.
    assign w_sh_lo = {1'b0, i_off, 3'b000};
    assign w_sh_hi = 7'd64 - w_sh_lo;
    assign w_raw   = (i_lo >> w_sh_lo) | (i_hi << w_sh_hi);

    always_comb begin
        o_data = '0;
        case (i_size)
            SZ_B:    o_data = {{56{i_signed & w_raw[7]}},  w_raw[7:0]};
            SZ_H:    o_data = {{48{i_signed & w_raw[15]}}, w_raw[15:0]};
            SZ_W:    o_data = {{32{i_signed & w_raw[31]}}, w_raw[31:0]};
            default: o_data = w_raw;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_adapter.sv
// -----------------------------------------------------------------------------
// lsu_dmem_adapter
// Load/store adapter in front of the simulation RAM's 64-bit data port.
// Takes one B/H/W/D request at a time, drives dword-aligned RAM beats with a
// bit-level write mask and lane-shifted write data, and returns an extended
// load result. Accesses crossing an 8-byte boundary use two beats (SPLIT_EN=1)
// or are rejected with resp_err (SPLIT_EN=0).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_wen              1 = store, 0 = load
//   req_addr             byte address
//   req_size             0=B 1=H 2=W 3=D
//   req_signed           sign-extend load result
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data
//   resp_err             straddle rejected (SPLIT_EN=0 only)
//   dmem_en/dmem_wen     RAM access / write strobe
//   dmem_addr            dword-aligned RAM address
//   dmem_rdata           RAM read data (same-cycle)
//   dmem_wdata/wmask     lane-shifted store data and bit mask
// -----------------------------------------------------------------------------
module lsu_dmem_adapter
    import lsu_pkg::*;
#(
    parameter bit SPLIT_EN           = 1'b1,
    parameter bit RESP_ZERO_ON_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_en,
    output logic [63:0] dmem_addr,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] dmem_wdata,
    output logic [63:0] dmem_wmask,
    output logic        dmem_wen
);

    lsu_state_t  r_state;
    logic        r_wen;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_lo;
    logic [63:0] r_hi;

    logic [2:0]  w_off;
    logic [3:0]  w_nb;
    logic [3:0]  w_end;
    logic        w_straddle;
    logic        w_reject;
    logic [63:0] w_base;
    logic [7:0]  w_be0;
    logic [7:0]  w_be1;
    logic [6:0]  w_sh0;
    logic [6:0]  w_sh1;
    logic [63:0] w_aligned;

    assign w_off      = r_addr[2:0];
    assign w_nb       = 4'd1 << r_size;
    // One past the last byte touched, relative to the lo dword (max 15).
    assign w_end      = {1'b0, w_off} + w_nb;
    assign w_straddle = (w_end > 4'd8);
    assign w_reject   = w_straddle & ~SPLIT_EN;
    assign w_base     = {r_addr[63:3], 3'b000};

    // Beat0 covers lanes [off, min(end,8)); beat1 covers lanes [0, end-8).
    always_comb begin
        w_be0 = '0;
        w_be1 = '0;
        for (int i = 0; i < 8; i++) begin
            w_be0[i] = (i >= int'(w_off)) && (i < int'(w_end));
            w_be1[i] = ((i + 8) < int'(w_end));
        end
    end

    // Beat1 only occurs with off >= 1, so its shift stays within 8..56.
    assign w_sh0 = {1'b0, w_off, 3'b000};
    assign w_sh1 = 7'd64 - w_sh0;

    lsu_load_align u_align (
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_off    (w_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_aligned)
    );

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        dmem_en    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wmask = '0;
        dmem_wen   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_BEAT0: begin
                // A rejected straddle spends this cycle without touching RAM.
                if (!w_reject) begin
                    dmem_en   = 1'b1;
                    dmem_addr = w_base;
                    dmem_wen  = r_wen;
                    if (r_wen) begin
                        dmem_wmask = byte_mask_expand(w_be0);
                        dmem_wdata = r_wdata << w_sh0;
                    end
                end
            end
            ST_BEAT1: begin
                dmem_en   = 1'b1;
                dmem_addr = w_base + 64'd8;
                dmem_wen  = r_wen;
                if (r_wen) begin
                    dmem_wmask = byte_mask_expand(w_be1);
                    dmem_wdata = r_wdata >> w_sh1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = w_reject;
                if (!w_reject && !(r_wen && RESP_ZERO_ON_WRITE)) begin
                    resp_rdata = w_aligned;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wen    <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SZ_B;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wen    <= req_wen;
                        r_signed <= req_signed;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_state  <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    r_lo <= dmem_rdata;
                    // hi stays zero unless a second beat refills it
                    r_hi <= '0;
                    if (w_straddle && SPLIT_EN) begin
                        r_state <= ST_BEAT1;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                ST_BEAT1: begin
                    r_hi    <= dmem_rdata;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_adapter.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem_adapter
// Bench for lsu_dmem_adapter: a split-enabled instance backed by a small RAM
// model, and a split-disabled instance used for the straddle-reject case.
// -----------------------------------------------------------------------------
module tb_lsu_dmem_adapter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        dmem_en;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_rdata;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;
    logic        dmem_wen;

    logic        req_valid_b;
    logic        req_ready_b;
    logic        resp_valid_b;
    logic [63:0] resp_rdata_b;
    logic        resp_err_b;
    logic        dmem_en_b;
    logic [63:0] dmem_addr_b;
    logic [63:0] dmem_rdata_b;
    logic [63:0] dmem_wdata_b;
    logic [63:0] dmem_wmask_b;
    logic        dmem_wen_b;

    int checks = 0;
    int errors = 0;

    lsu_dmem_adapter #(.SPLIT_EN(1'b1), .RESP_ZERO_ON_WRITE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_en    (dmem_en),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_wdata (dmem_wdata),
        .dmem_wmask (dmem_wmask),
        .dmem_wen   (dmem_wen)
    );

    lsu_dmem_adapter #(.SPLIT_EN(1'b0), .RESP_ZERO_ON_WRITE(1'b1)) dut_ns (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid_b),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b),
        .dmem_en    (dmem_en_b),
        .dmem_addr  (dmem_addr_b),
        .dmem_rdata (dmem_rdata_b),
        .dmem_wdata (dmem_wdata_b),
        .dmem_wmask (dmem_wmask_b),
        .dmem_wen   (dmem_wen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-dword RAM model indexed by address bits [6:3]; combinational read,
    // masked write at posedge. Preloading goes through the same process.
    logic [63:0] mem [0:15];
    logic        pre_en;
    logic [3:0]  pre_i0, pre_i1;
    logic [63:0] pre_d0, pre_d1;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_i0] <= pre_d0;
            mem[pre_i1] <= pre_d1;
        end else if (dmem_en && dmem_wen) begin
            mem[dmem_addr[6:3]] <= (mem[dmem_addr[6:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
        end
    end

    assign dmem_rdata   = mem[dmem_addr[6:3]];
    assign dmem_rdata_b = 64'h0;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] wdata;
        logic [63:0] ram_lo;
        logic [63:0] ram_hi;
        int          beats;
        logic [63:0] exp_rdata;
        logic [63:0] a0, m0, d0;
        logic [63:0] a1, m1, d1;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    vec_t  vecs[11];

    function automatic vec_t mk(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [63:0] wdata, input logic [63:0] lo,
                                input logic [63:0] hi, input int beats, input logic [63:0] exp_rdata,
                                input logic [63:0] a0, input logic [63:0] m0, input logic [63:0] d0,
                                input logic [63:0] a1, input logic [63:0] m1, input logic [63:0] d1);
        vec_t v;
        v.wen = wen; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
        v.ram_lo = lo; v.ram_hi = hi; v.beats = beats; v.exp_rdata = exp_rdata;
        v.a0 = a0; v.m0 = m0; v.d0 = d0; v.a1 = a1; v.m1 = m1; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        resp_t r;
        pre_i0 = v.addr[6:3];
        pre_i1 = v.addr[6:3] + 4'd1;
        pre_d0 = v.ram_lo;
        pre_d1 = v.ram_hi;
        pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
        chk($sformatf("v%0d ready idle", k), {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_wen    = v.wen;
        req_addr   = v.addr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_wdata  = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r.rdata = v.exp_rdata;
        r.err   = 1'b0;
        sb_q.push_back(r);
        chk($sformatf("v%0d b0 en", k),    {63'd0, dmem_en},  64'd1);
        chk($sformatf("v%0d b0 addr", k),  dmem_addr,         v.a0);
        chk($sformatf("v%0d b0 wen", k),   {63'd0, dmem_wen}, {63'd0, v.wen});
        chk($sformatf("v%0d b0 wmask", k), dmem_wmask,        v.m0);
        chk($sformatf("v%0d b0 wdata", k), dmem_wdata,        v.d0);
        if (v.beats == 2) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d b1 en", k),    {63'd0, dmem_en},  64'd1);
            chk($sformatf("v%0d b1 addr", k),  dmem_addr,         v.a1);
            chk($sformatf("v%0d b1 wen", k),   {63'd0, dmem_wen}, {63'd0, v.wen});
            chk($sformatf("v%0d b1 wmask", k), dmem_wmask,        v.m1);
            chk($sformatf("v%0d b1 wdata", k), dmem_wdata,        v.d1);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d resp_valid latency", k), {63'd0, resp_valid}, 64'd1);
        chk($sformatf("v%0d ready in resp", k), {63'd0, req_ready}, 64'd0);
        chk($sformatf("v%0d en in resp", k), {63'd0, dmem_en}, 64'd0);
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d scoreboard underflow", k), 64'd1, 64'd0);
            end else begin
                r = sb_q.pop_front();
                chk($sformatf("v%0d rdata", k), resp_rdata, r.rdata);
                chk($sformatf("v%0d err", k), {63'd0, resp_err}, {63'd0, r.err});
            end
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d resp one-shot", k), {63'd0, resp_valid}, 64'd0);
        chk($sformatf("v%0d ready after", k), {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid_b = 1'b0;
        req_wen = 1'b0; req_addr = '0; req_size = 2'd0; req_signed = 1'b0; req_wdata = '0;
        pre_en = 1'b0; pre_i0 = '0; pre_i1 = '0; pre_d0 = '0; pre_d1 = '0;

        //                wen   addr                    sz    sgn   wdata                  ram_lo                 ram_hi                 bt exp_rdata              a0                     m0                     d0                     a1                     m1                     d1
        vecs[0]  = mk(1'b0, 64'h0000_0000_8000_0010, 2'd3, 1'b0, 64'h0,                 64'h1122334455667788, 64'h0,                 1, 64'h1122334455667788, 64'h0000_0000_8000_0010, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[1]  = mk(1'b0, 64'h0000_0000_8000_0003, 2'd0, 1'b1, 64'h0,                 64'h0000_0000_80FF_0000, 64'h0,               1, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[2]  = mk(1'b0, 64'h0000_0000_8000_0003, 2'd0, 1'b0, 64'h0,                 64'h0000_0000_80FF_0000, 64'h0,               1, 64'h0000_0000_0000_0080, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[3]  = mk(1'b1, 64'h0000_0000_8000_0024, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'h0,                 64'h0,               1, 64'h0, 64'h0000_0000_8000_0020, 64'hFFFF_FFFF_0000_0000, 64'hDEAD_BEEF_0000_0000, 64'h0, 64'h0, 64'h0);
        vecs[4]  = mk(1'b1, 64'h0000_0000_8000_0007, 2'd1, 1'b0, 64'h0000_0000_0000_ABCD, 64'h0,                 64'h0,               2, 64'h0, 64'h0000_0000_8000_0000, 64'hFF00_0000_0000_0000, 64'hCD00_0000_0000_0000, 64'h0000_0000_8000_0008, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00AB);
        vecs[5]  = mk(1'b0, 64'h0000_0000_8000_0006, 2'd2, 1'b1, 64'h0,                 64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_0000_F0E1, 2, 64'hFFFF_FFFF_F0E1_AAAA, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 64'h0000_0000_8000_0008, 64'h0, 64'h0);
        vecs[6]  = mk(1'b0, 64'h0000_0000_8000_0005, 2'd3, 1'b0, 64'h0,                 64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908, 2, 64'h0C0B_0A09_0807_0605, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 64'h0000_0000_8000_0008, 64'h0, 64'h0);
        vecs[7]  = mk(1'b0, 64'h0000_0000_8000_0016, 2'd1, 1'b1, 64'h0,                 64'h8001_0000_0000_0000, 64'h0,               1, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_8000_0010, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[8]  = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b0, 64'h0,                 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_5566, 2, 64'h0000_0000_5566_1234, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[9]  = mk(1'b1, 64'h0000_0000_8000_0003, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0,                 64'h0,               2, 64'h0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FF00_0000, 64'h6789_ABCD_EF00_0000, 64'h0000_0000_8000_0008, 64'h0000_0000_00FF_FFFF, 64'h0000_0000_0001_2345);
        vecs[10] = mk(1'b1, 64'h0000_0000_8000_0000, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0,                 64'h0,               1, 64'h0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 64'h0, 64'h0);

        // Reset state
        #1;
        chk("reset req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset dmem_en", {63'd0, dmem_en}, 64'd0);
        chk("reset dmem_addr", dmem_addr, 64'd0);
        chk("reset dmem_wmask", dmem_wmask, 64'd0);
        chk("reset dmem_wdata", dmem_wdata, 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset resp_err", {63'd0, resp_err}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            run_vec(k, vecs[k]);
        end

        // Reset during BEAT1 of a split load
        pre_i0 = 4'd0; pre_i1 = 4'd1;
        pre_d0 = vecs[6].ram_lo; pre_d1 = vecs[6].ram_hi; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = vecs[6].addr;
        req_size = vecs[6].size; req_signed = 1'b0; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid beat1 addr", dmem_addr, 64'h0000_0000_8000_0008);
        rst = 1'b1;
        #1;
        chk("rstmid ready", {63'd0, req_ready}, 64'd1);
        chk("rstmid dmem_en", {63'd0, dmem_en}, 64'd0);
        chk("rstmid resp_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid no resp c%0d", c), {63'd0, resp_valid}, 64'd0);
        end
        run_vec(100, vecs[0]);

        // Split-disabled instance: straddling store is rejected
        chk("ns ready idle", {63'd0, req_ready_b}, 64'd1);
        req_wen = 1'b1; req_addr = 64'h0000_0000_8000_0007; req_size = 2'd1;
        req_signed = 1'b0; req_wdata = 64'h0000_0000_0000_ABCD;
        req_valid_b = 1'b1;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        chk("ns b0 dmem_en", {63'd0, dmem_en_b}, 64'd0);
        chk("ns b0 dmem_wen", {63'd0, dmem_wen_b}, 64'd0);
        chk("ns b0 resp_valid", {63'd0, resp_valid_b}, 64'd0);
        @(posedge clk); #1;
        chk("ns resp_valid", {63'd0, resp_valid_b}, 64'd1);
        chk("ns resp_err", {63'd0, resp_err_b}, 64'd1);
        chk("ns resp_rdata", resp_rdata_b, 64'd0);
        chk("ns resp dmem_en", {63'd0, dmem_en_b}, 64'd0);
        @(posedge clk); #1;
        chk("ns resp one-shot", {63'd0, resp_valid_b}, 64'd0);
        chk("ns ready after", {63'd0, req_ready_b}, 64'd1);

        // Split-disabled instance: aligned load still accesses RAM
        req_wen = 1'b0; req_addr = 64'h0000_0000_8000_0010; req_size = 2'd3;
        req_valid_b = 1'b1;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        chk("ns load dmem_en", {63'd0, dmem_en_b}, 64'd1);
        chk("ns load dmem_addr", dmem_addr_b, 64'h0000_0000_8000_0010);
        chk("ns load wmask", dmem_wmask_b, 64'd0);
        chk("ns load wdata", dmem_wdata_b, 64'd0);
        @(posedge clk); #1;
        chk("ns load resp_valid", {63'd0, resp_valid_b}, 64'd1);
        chk("ns load resp_err", {63'd0, resp_err_b}, 64'd0);
        @(posedge clk); #1;

        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
